inst_prefetch_queue: RTL and testbench

Instruction prefetch unit that replaces the bare PC register and fetch-to-decode instruction register in the 5-stage pipeline. It sits directly upstream of decode. It issues sequential fetches to a fixed-latency instruction memory and buffers the returned words with their PC+4 in a small FIFO. It presents them to decode through a valid/ready handshake, where ready is the decode stall inverted. A taken branch or jump from the memory stage redirects it, and the redirect flushes all buffered and in-flight fetches.

---
 rtl/inst_prefetch_queue.sv | 96 +++++++++
 tb/tb_inst_prefetch_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch from fixed-latency imem into a show-ahead FIFO for decode.
// Optional same-cycle bypass of the returning word into an empty queue is enabled by defining PFQ_BYPASS_EN.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       deq_valid,
    output logic [31:0]                deq_inst,
    output logic [31:0]                deq_pc4,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]      fetch_pc;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc4_mem  [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit;
    logic             empty, push, pop, bypass;

    // An outstanding fetch already owns a slot, so a return can never find the queue full.
    assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign empty     = (count == '0);
    assign imem_req  = ~rst & ~redirect & (credit < {1'b0, FULL});
    assign imem_addr = fetch_pc;

`ifdef PFQ_BYPASS_EN
    assign bypass = empty & inflight & ~redirect & deq_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push      = inflight & ~redirect & ~bypass;
    assign pop       = ~empty & ~redirect & deq_ready;
    assign deq_valid = (~empty & ~redirect) | bypass;
    assign occupancy = count;

    always_comb begin
        deq_inst = '0;
        deq_pc4  = '0;
        if (bypass) begin
            deq_inst = imem_rdata;
            deq_pc4  = inflight_pc + 32'd4;
        end else if (!empty) begin
            deq_inst = inst_mem[rd_ptr];
            deq_pc4  = pc4_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight    <= imem_req;
            inflight_pc <= fetch_pc;
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (imem_req) fetch_pc <= fetch_pc + 32'd4;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            assert (count != FULL);
            inst_mem[wr_ptr] <= imem_rdata;
            pc4_mem[wr_ptr]  <= inflight_pc + 32'd4;
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue; imem model returns addr>>2 one cycle after each address.
module tb_inst_prefetch_queue;
`ifdef PFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        deq_valid;
    logic [31:0] deq_inst, deq_pc4;
    logic        deq_ready = 1'b1;
    logic [2:0]  occupancy;

    int total = 0;
    int bad = 0;

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc4(deq_pc4),
        .deq_ready(deq_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= imem_addr >> 2;

    // Leaves the bench at the start of the first cycle after reset release.
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_ready = rdy;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; deq_ready = 1'b0; #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", deq_valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        total++; if (deq_inst !== 32'd0 || deq_pc4 !== 32'd0) begin bad++; $display("FAIL rst_data got=%h/%h exp=0/0", deq_inst, deq_pc4); end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 5; k++) @(negedge clk);
        #2 rst = 1'b1; #1;
        total++; if (occupancy !== 3'd0 || deq_valid !== 1'b0 || imem_req !== 1'b0) begin bad++;
            $display("FAIL midrst got occ=%0d v=%b req=%b exp 0/0/0", occupancy, deq_valid, imem_req); end
        @(negedge clk); rst = 1'b0; #1;
        total++; if (deq_valid !== 1'b0 || imem_addr !== 32'd0 || occupancy !== 3'd0) begin bad++;
            $display("FAIL postrst got v=%b addr=%h occ=%0d exp 0/0/0", deq_valid, imem_addr, occupancy); end
        @(negedge clk);
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin bad++;
                $display("FAIL stream_req k=%0d got req=%b addr=%h exp 1/%h", k, imem_req, imem_addr, 32'(4*k)); end
            total++; if (deq_valid !== (k >= LAT)) begin bad++; $display("FAIL stream_valid k=%0d got=%b", k, deq_valid); end
            if (k >= LAT) begin
                total++; if (deq_inst !== 32'(k-LAT) || deq_pc4 !== 32'(4*(k-LAT+1))) begin bad++;
                    $display("FAIL stream_data k=%0d got=%h/%h exp=%h/%h", k, deq_inst, deq_pc4, 32'(k-LAT), 32'(4*(k-LAT+1))); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full;
        int exp_occ [13] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 3, 2, 2, 2};
        logic exp_req;
        do_reset(1'b0);
        for (int k = 0; k < 13; k++) begin
            deq_ready = (k >= 8); #1;
            exp_req = (k <= 3) || (k >= 9);
            total++; if (occupancy !== 3'(exp_occ[k])) begin bad++; $display("FAIL full_occ k=%0d got=%0d exp=%0d", k, occupancy, exp_occ[k]); end
            total++; if (imem_req !== exp_req) begin bad++; $display("FAIL full_req k=%0d got=%b exp=%b", k, imem_req, exp_req); end
            if (k >= 9) begin
                total++; if (imem_addr !== 32'(16 + 4*(k-9))) begin bad++; $display("FAIL full_addr k=%0d got=%h", k, imem_addr); end
            end
            if (k >= 2) begin
                total++; if (deq_valid !== 1'b1 || deq_inst !== 32'((k < 8) ? 0 : k-8) || deq_pc4 !== 32'((k < 8) ? 4 : 4*(k-7))) begin bad++;
                    $display("FAIL full_head k=%0d got v=%b %h/%h", k, deq_valid, deq_inst, deq_pc4); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect;
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h40; #1;
        total++; if (occupancy !== 3'd3 || deq_valid !== 1'b0 || imem_req !== 1'b0) begin bad++;
            $display("FAIL redir_cycle got occ=%0d v=%b req=%b exp 3/0/0", occupancy, deq_valid, imem_req); end
        @(negedge clk);
        redirect = 1'b0; deq_ready = 1'b1;
        for (int k = 5; k < 10; k++) begin
            #1;
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'(32'h40 + 4*(k-5))) begin bad++;
                $display("FAIL redir_addr k=%0d got=%h", k, imem_addr); end
            total++; if (deq_valid !== (k >= 5+LAT)) begin bad++; $display("FAIL redir_valid k=%0d got=%b", k, deq_valid); end
            if (k >= 5+LAT) begin
                total++; if (deq_inst !== 32'(32'h10 + k-5-LAT) || deq_pc4 !== 32'(32'h44 + 4*(k-5-LAT))) begin bad++;
                    $display("FAIL redir_data k=%0d got=%h/%h", k, deq_inst, deq_pc4); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_pop;
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h43; #1;
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL rpop_valid got=%b exp=0", deq_valid); end
        @(negedge clk);
        redirect = 1'b0; #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || occupancy !== 3'd0) begin bad++;
            $display("FAIL rpop_addr got req=%b addr=%h occ=%0d exp 1/40/0", imem_req, imem_addr, occupancy); end
        for (int k = 0; k < LAT; k++) @(negedge clk);
        #1;
        total++; if (deq_valid !== 1'b1 || deq_inst !== 32'h10 || deq_pc4 !== 32'h44) begin bad++;
            $display("FAIL rpop_first got v=%b %h/%h exp 1 10/44", deq_valid, deq_inst, deq_pc4); end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [31:0] ea, ep;
        do_reset(1'b1);
        @(negedge clk); @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect = 1'b0;
        for (int k = 3; k < 9; k++) begin
            #1;
            ea = 32'hFFFF_FFF8 + 32'(4*(k-3));
            total++; if (imem_addr !== ea) begin bad++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, imem_addr, ea); end
            if (k >= 3+LAT) begin
                ep = 32'hFFFF_FFF8 + 32'(4*(k-3-LAT));
                total++; if (deq_valid !== 1'b1 || deq_inst !== (ep >> 2) || deq_pc4 !== ep + 32'd4) begin bad++;
                    $display("FAIL wrap_data k=%0d got v=%b %h/%h exp %h/%h", k, deq_valid, deq_inst, deq_pc4, ep >> 2, ep + 32'd4); end
            end
            @(negedge clk);
        end
    endtask

`ifdef PFQ_BYPASS_EN
    task automatic test_bypass;
        do_reset(1'b1);
        @(negedge clk); #1;
        total++; if (deq_valid !== 1'b1 || deq_inst !== 32'd0 || deq_pc4 !== 32'd4 || occupancy !== 3'd0) begin bad++;
            $display("FAIL byp_first got v=%b %h/%h occ=%0d", deq_valid, deq_inst, deq_pc4, occupancy); end
        @(negedge clk); #1;
        total++; if (deq_inst !== 32'd1 || occupancy !== 3'd0) begin bad++; $display("FAIL byp_second got %h occ=%0d", deq_inst, occupancy); end
        @(negedge clk); deq_ready = 1'b0; #1;
        total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL byp_stall got=%b exp=0", deq_valid); end
        @(negedge clk); deq_ready = 1'b1; #1;
        total++; if (deq_valid !== 1'b1 || deq_inst !== 32'd2 || occupancy !== 3'd1) begin bad++;
            $display("FAIL byp_written got v=%b %h occ=%0d exp 1 2 1", deq_valid, deq_inst, occupancy); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_pop();
        test_wrap();
`ifdef PFQ_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
